// File: rtl/aes128_iter_encrypt.sv
// aes128_iter_encrypt: iterative AES-128 encryptor, UNROLL rounds per clock, valid/ready on both sides
module aes128_iter_encrypt #(
  parameter int Nb = 128,
  parameter int UNROLL = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [Nb-1:0] plain_text,
  input  logic [Nb-1:0] round_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [Nb-1:0] cipher_text,
  output logic          busy
);
  localparam int NR = 10;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  if (Nb != 128 || !(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_param
    $error("aes128_iter_encrypt: Nb must be 128 and UNROLL one of 1, 2, 5, 10");
  end
  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047-8*int'(x) -: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] r);
    return r == 4'd9 ? 8'h1b : r == 4'd10 ? 8'h36 : 8'h01 << (r - 4'd1);
  endfunction
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [127:0] t;
    for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sb(s[127-8*((i+4*(i%4))%16) -: 8]);
    for (int c = 0; c < 4; c++) if (!last) t[127-32*c -: 32] = mix_col(t[127-32*c -: 32]);
    return t ^ k;
  endfunction
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rcon(r), 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  logic [1:0] fsm_q, fsm_d;
  logic [127:0] st_q, st_d, key_q, key_d, ct_q, ct_d, s_run, k_run;
  logic [3:0] rnd_q, rnd_d;
  logic ov_q, ov_d, fin, accept;
  assign in_ready = fsm_q == IDLE || (fsm_q == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign fin = rnd_q + 4'(UNROLL - 1) == 4'(NR);
  assign out_valid = ov_q;
  assign cipher_text = ct_q;
  assign busy = fsm_q == RUN;
  // UNROLL chained rounds with the key schedule stepping alongside
  always_comb begin
    s_run = st_q;
    k_run = key_q;
    for (int i = 0; i < UNROLL; i++) begin
      k_run = next_key(k_run, rnd_q + 4'(i));
      s_run = enc_round(s_run, k_run, rnd_q + 4'(i) == 4'(NR));
    end
  end
  // next state: advance rounds in RUN, release in DONE, a new accept overrides both
  always_comb begin
    fsm_d = fsm_q;
    st_d = st_q;
    key_d = key_q;
    rnd_d = rnd_q;
    ct_d = ct_q;
    ov_d = ov_q;
    if (fsm_q == RUN) begin
      st_d = s_run;
      key_d = k_run;
      rnd_d = rnd_q + 4'(UNROLL);
      if (fin) begin
        ct_d = s_run;
        ov_d = 1'b1;
        fsm_d = DONE;
      end
    end else if (fsm_q == DONE && out_ready) begin
      ov_d = 1'b0;
      fsm_d = IDLE;
    end
    if (accept) begin
      st_d = plain_text ^ round_key;
      key_d = round_key;
      rnd_d = 4'd1;
      fsm_d = RUN;
    end
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q <= IDLE;
      st_q <= '0;
      key_q <= '0;
      ct_q <= '0;
      rnd_q <= '0;
      ov_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      st_q <= st_d;
      key_q <= key_d;
      ct_q <= ct_d;
      rnd_q <= rnd_d;
      ov_q <= ov_d;
    end
  end
endmodule

// File: tb/tb_aes128_iter_encrypt.sv
// tb_aes128_iter_encrypt: checks four unroll variants against a byte-array AES model
module tb_aes128_iter_encrypt;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] in_valid = '0, out_ready = '0, in_ready, out_valid, busy;
  logic [127:0] pt_i[4], key_i[4], ct_o[4];
  logic [7:0] sbt[256];
  int vec = 0, errs = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes128_iter_encrypt #(.UNROLL(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .plain_text(pt_i[g]), .round_key(key_i[g]), .out_valid(out_valid[g]),
      .out_ready(out_ready[g]), .cipher_text(ct_o[g]), .busy(busy[g]));
  end
  function automatic int lat(int d);
    return d == 0 ? 10 : d == 1 ? 5 : d == 2 ? 2 : 1;
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s[16], t[16], rc, cf[4];
    logic [31:0] w[44], tmp;
    logic [127:0] res;
    cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbt[s[(i%4)+4*((i/4+i%4)%4)]];
      for (int i = 0; i < 16; i++) begin
        s[i] = 8'h00;
        if (r == 10) s[i] = t[i];
        else for (int j = 0; j < 4; j++) s[i] ^= gmul(cf[(j-i%4+4)%4], t[4*(i/4)+j]);
        s[i] ^= w[4*r+i/4][31-8*(i%4) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input int d, output int n);
    n = 0;
    while (out_valid[d] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      vec++;
      if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || ct_o[d] !== 128'h0) begin
        errs++;
        $display("FAIL reset[%0d]: got ov=%b busy=%b ct=%h want 0 0 0", d, out_valid[d], busy[d], ct_o[d]);
      end
    end
    reset = 1'b1;
    tick();
    vec++;
    if (in_ready !== 4'hf) begin
      errs++;
      $display("FAIL reset in_ready: got %b want 1111", in_ready);
    end
  endtask
  task automatic test_latency(input int d, input logic [127:0] p, input logic [127:0] k,
                              input logic [127:0] exp, input string nm);
    int n;
    pt_i[d] = p;
    key_i[d] = k;
    in_valid[d] = 1'b1;
    out_ready[d] = 1'b1;
    vec++;
    if (in_ready[d] !== 1'b1) begin
      errs++;
      $display("FAIL %s[%0d] idle in_ready: got %b want 1", nm, d, in_ready[d]);
    end
    tick();
    in_valid[d] = 1'b0;
    vec++;
    if (busy[d] !== 1'b1) begin
      errs++;
      $display("FAIL %s[%0d] busy after accept: got %b want 1", nm, d, busy[d]);
    end
    wait_valid(d, n);
    vec++;
    if (n != lat(d)) begin
      errs++;
      $display("FAIL %s[%0d] latency: got %0d want %0d", nm, d, n, lat(d));
    end
    vec++;
    if (ct_o[d] !== exp) begin
      errs++;
      $display("FAIL %s[%0d] cipher_text: got %h want %h", nm, d, ct_o[d], exp);
    end
    tick();
    vec++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
      errs++;
      $display("FAIL %s[%0d] release: got ov=%b ir=%b busy=%b want 0 1 0", nm, d, out_valid[d], in_ready[d], busy[d]);
    end
  endtask
  task automatic test_random();
    logic [127:0] p, k;
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 4; i++) begin
        p = rnd128();
        k = rnd128();
        test_latency(d, p, k, ref_enc(p, k), "random");
      end
    end
  endtask
  task automatic test_hold(input int d);
    int n;
    pt_i[d] = '0;
    key_i[d] = '0;
    out_ready[d] = 1'b0;
    in_valid[d] = 1'b1;
    tick();
    in_valid[d] = 1'b0;
    wait_valid(d, n);
    vec++;
    if (n != lat(d)) begin
      errs++;
      $display("FAIL hold[%0d] latency: got %0d want %0d", d, n, lat(d));
    end
    in_valid[d] = 1'b1;
    pt_i[d] = rnd128();
    for (int i = 0; i < 7; i++) begin
      tick();
      vec++;
      if (out_valid[d] !== 1'b1 || ct_o[d] !== 128'h66e94bd4ef8a2c3b884cfa59ca342b2e || in_ready[d] !== 1'b0 || busy[d] !== 1'b0) begin
        errs++;
        $display("FAIL hold[%0d] cycle %0d: got ov=%b ir=%b busy=%b ct=%h want 1 0 0 66e94bd4ef8a2c3b884cfa59ca342b2e",
                 d, i, out_valid[d], in_ready[d], busy[d], ct_o[d]);
      end
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    vec++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || ct_o[d] !== 128'h66e94bd4ef8a2c3b884cfa59ca342b2e) begin
      errs++;
      $display("FAIL hold[%0d] pulse: got ov=%b ir=%b ct=%h want 0 1 retained", d, out_valid[d], in_ready[d], ct_o[d]);
    end
  endtask
  task automatic test_ignore_inputs(input int d);
    logic [127:0] p, k, e;
    int n;
    p = rnd128();
    k = rnd128();
    e = ref_enc(p, k);
    pt_i[d] = p;
    key_i[d] = k;
    in_valid[d] = 1'b1;
    out_ready[d] = 1'b0;
    tick();
    n = 0;
    while (out_valid[d] !== 1'b1 && n < 20) begin
      pt_i[d] = rnd128();
      key_i[d] = rnd128();
      vec++;
      if (in_ready[d] !== 1'b0) begin
        errs++;
        $display("FAIL ignore[%0d] run in_ready: got %b want 0", d, in_ready[d]);
      end
      tick();
      n++;
    end
    vec++;
    if (n != lat(d) || ct_o[d] !== e) begin
      errs++;
      $display("FAIL ignore[%0d]: got lat=%0d ct=%h want lat=%0d ct=%h", d, n, ct_o[d], lat(d), e);
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
  endtask
  task automatic test_back_to_back(input int d);
    logic [127:0] a, ka, b, kb, ea, eb;
    int n;
    a = rnd128();
    ka = rnd128();
    b = rnd128();
    kb = rnd128();
    ea = ref_enc(a, ka);
    eb = ref_enc(b, kb);
    pt_i[d] = a;
    key_i[d] = ka;
    in_valid[d] = 1'b1;
    out_ready[d] = 1'b1;
    tick();
    pt_i[d] = b;
    key_i[d] = kb;
    n = 0;
    while (out_valid[d] !== 1'b1 && n < 20) begin
      vec++;
      if (in_ready[d] !== 1'b0) begin
        errs++;
        $display("FAIL b2b[%0d] run in_ready: got %b want 0", d, in_ready[d]);
      end
      tick();
      n++;
    end
    vec++;
    if (n != lat(d) || ct_o[d] !== ea || in_ready[d] !== 1'b1) begin
      errs++;
      $display("FAIL b2b[%0d] first: got lat=%0d ct=%h ir=%b want lat=%0d ct=%h ir=1", d, n, ct_o[d], in_ready[d], lat(d), ea);
    end
    tick();
    in_valid[d] = 1'b0;
    vec++;
    if (out_valid[d] !== 1'b0 || busy[d] !== 1'b1 || ct_o[d] !== ea) begin
      errs++;
      $display("FAIL b2b[%0d] handover: got ov=%b busy=%b ct=%h want 0 1 %h", d, out_valid[d], busy[d], ct_o[d], ea);
    end
    wait_valid(d, n);
    vec++;
    if (n != lat(d) || ct_o[d] !== eb) begin
      errs++;
      $display("FAIL b2b[%0d] second: got lat=%0d ct=%h want lat=%0d ct=%h", d, n, ct_o[d], lat(d), eb);
    end
    tick();
    out_ready[d] = 1'b0;
  endtask
  task automatic test_reset_mid();
    logic [127:0] p, k;
    for (int d = 0; d < 4; d += 2) begin
      pt_i[d] = rnd128();
      key_i[d] = rnd128();
      in_valid[d] = 1'b1;
      out_ready[d] = 1'b0;
    end
    tick();
    in_valid = '0;
    repeat (3) tick();
    vec++;
    if (busy[0] !== 1'b1 || out_valid[2] !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid setup: got busy0=%b ov2=%b want 1 1", busy[0], out_valid[2]);
    end
    #1 reset = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      vec++;
      if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || ct_o[d] !== 128'h0) begin
        errs++;
        $display("FAIL reset_mid[%0d]: got ov=%b busy=%b ct=%h want 0 0 0", d, out_valid[d], busy[d], ct_o[d]);
      end
    end
    #3 reset = 1'b1;
    tick();
    p = rnd128();
    k = rnd128();
    test_latency(0, p, k, ref_enc(p, k), "post_reset");
  endtask
  initial begin
    logic [7:0] inv;
    for (int d = 0; d < 4; d++) begin
      pt_i[d] = '0;
      key_i[d] = '0;
    end
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      sbt[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    test_reset();
    test_latency(0, 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                 128'h3925841d02dc09fbdc118597196a0b32, "fips_a1");
    for (int d = 3; d >= 1; d--)
      test_latency(d, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a, "fips_c1");
    test_random();
    for (int d = 0; d < 4; d++) test_hold(d);
    test_ignore_inputs(0);
    test_ignore_inputs(2);
    for (int d = 0; d < 4; d++) test_back_to_back(d);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
